// File: rtl/step_to_position.sv
// step_to_position
//   Decodes a STEP/DIR pulse stream into a signed microstep position.
//   It also measures the step period, flags motion with a stall timeout,
//   and pulses when an armed target position is reached.
//
//   Optional build macro: STEP_GLITCH_FILTER_EN
//     When defined, a step is accepted only after the synchronized step has
//     been high for MIN_HIGH_CYC consecutive cycles.
//     When undefined, every synchronized rising edge is accepted.
//
//   Ports
//     clk_i            system clock
//     reset_n_i        asynchronous active-low reset
//     enable_i         decoder enable; low ignores steps and holds position
//     clear_i          synchronous clear of position, timer, period and target
//     step_i           asynchronous step input; a rising edge is one microstep
//     dir_i            asynchronous direction; 1 = increment, 0 = decrement
//     target_valid_i   one-cycle strobe that loads and arms target_i
//     target_i         signed target position
//     position_o       signed accumulated position (wraps modulo 2^POS_W)
//     period_o         clk_i cycles between the last two accepted steps; 0 = stopped
//     period_valid_o   one-cycle pulse when period_o updates
//     moving_o         high while steps arrive within the timeout
//     target_reached_o one-cycle pulse when the armed target is hit
module step_to_position #(
  parameter int unsigned POS_W        = 32,
  parameter int unsigned PERIOD_W     = 32,
  parameter int unsigned SYSCLK       = 25000000,
  parameter int unsigned TIMEOUT_US   = 10000,
  parameter int unsigned MIN_HIGH_CYC = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       step_i,
  input  logic                       dir_i,
  input  logic                       target_valid_i,
  input  logic signed [POS_W-1:0]    target_i,
  output logic signed [POS_W-1:0]    position_o,
  output logic        [PERIOD_W-1:0] period_o,
  output logic                       period_valid_o,
  output logic                       moving_o,
  output logic                       target_reached_o
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_CYC = PERIOD_W'((SYSCLK / 32'd1000000) * TIMEOUT_US);
  localparam logic [PERIOD_W-1:0] TIMER_ONE   = PERIOD_W'(1);
  localparam logic [POS_W-1:0]    POS_ONE     = POS_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_q, state_d;
  logic [PERIOD_W-1:0]        timer_q, timer_d, period_d;
  logic signed [POS_W-1:0]    pos_d;
  logic                       pv_d;
  logic                       step_meta, step_s, dir_meta, dir_s;
  logic                       step_hit, accept, timeout;
  logic                       armed_q;
  logic signed [POS_W-1:0]    target_q;

  // Synchronizers run regardless of enable_i, so re-enabling while step_i is
  // already high does not produce a false edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step_meta <= 1'b0;
      step_s    <= 1'b0;
      dir_meta  <= 1'b0;
      dir_s     <= 1'b0;
    end else begin
      step_meta <= step_i;
      step_s    <= step_meta;
      dir_meta  <= dir_i;
      dir_s     <= dir_meta;
    end
  end

`ifdef STEP_GLITCH_FILTER_EN
  localparam int unsigned HC_W = $clog2(MIN_HIGH_CYC + 1);

  logic [HC_W-1:0] high_cnt;

  // Counts the high cycles that came before the current one. It saturates
  // at MIN_HIGH_CYC, so a long high is accepted only once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      high_cnt <= '0;
    end else if (!step_s) begin
      high_cnt <= '0;
    end else if (high_cnt != HC_W'(MIN_HIGH_CYC)) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end

  assign step_hit = step_s && (high_cnt == HC_W'(MIN_HIGH_CYC - 1));
`else
  logic step_prev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step_prev <= 1'b0;
    end else begin
      step_prev <= step_s;
    end
  end

  assign step_hit = step_s && !step_prev;
`endif

  assign accept  = enable_i && step_hit;
  assign timeout = (timer_q >= TIMEOUT_CYC);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      position_o     <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      position_o     <= pos_d;
      period_o       <= period_d;
      period_valid_o <= pv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pos_d    = position_o;
    period_d = period_o;
    pv_d     = 1'b0;
    if (clear_i) begin
      state_d  = IDLE;
      timer_d  = '0;
      pos_d    = '0;
      period_d = '0;
    end else if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      if (accept) begin
        pos_d = dir_s ? position_o + POS_ONE : position_o - POS_ONE;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = RUN;
            timer_d = TIMER_ONE;
          end
        end
        RUN: begin
          // An edge arriving in the timeout cycle keeps the decoder in RUN.
          if (accept) begin
            period_d = timer_q;
            pv_d     = 1'b1;
            timer_d  = TIMER_ONE;
          end else if (timeout) begin
            state_d  = IDLE;
            timer_d  = '0;
            period_d = '0;
            pv_d     = 1'b1;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign moving_o = (state_q == RUN);

  // The comparison uses the registered position. A load that coincides with
  // a step edge is therefore checked against the post-step position.
  assign target_reached_o = armed_q && (position_o == target_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      armed_q  <= 1'b0;
      target_q <= '0;
    end else if (clear_i) begin
      armed_q <= 1'b0;
    end else if (target_valid_i) begin
      target_q <= target_i;
      armed_q  <= 1'b1;
    end else if (target_reached_o) begin
      armed_q <= 1'b0;
    end
  end

endmodule
